// File: rtl/oled_frame_sequencer.sv
// SSD1306 link sequencer: panel reset timing, one-time init command list,
// then one 128x64 framebuffer refresh per request over a valid/ready byte stream.
module oled_frame_sequencer #(
  parameter int unsigned STARTUP_WAIT = 10000000,
  parameter int unsigned FB_BYTES     = 1024,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_req,
  output logic              busy,
  output logic              init_done,
  output logic              frame_done,
  output logic              fb_lock,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_rdata,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              byte_dc,
  output logic [7:0]        byte_data,
  output logic              oled_reset
);

  typedef enum logic [3:0] {
    POR_HIGH,
    POR_LOW,
    POR_HIGH2,
    INIT_CMD,
    IDLE,
    ADDR_CMD,
    FB_FETCH,
    FB_WAIT,
    FB_SEND,
    DONE
  } state_t;

  localparam logic [31:0]       WAIT_LAST = 32'(STARTUP_WAIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);
  localparam logic [4:0]        INIT_LAST = 5'd22;
  localparam logic [4:0]        ADDR_LAST = 5'd5;

  state_t      state;
  logic [31:0] cnt;
  logic [4:0]  idx;

  function automatic logic [7:0] init_byte(input logic [4:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      5'd0:  b = 8'hAE;
      5'd1:  b = 8'h81;
      5'd2:  b = 8'h7F;
      5'd3:  b = 8'hA6;
      5'd4:  b = 8'h20;
      5'd5:  b = 8'h00;
      5'd6:  b = 8'hC8;
      5'd7:  b = 8'h40;
      5'd8:  b = 8'hA1;
      5'd9:  b = 8'hA8;
      5'd10: b = 8'h3F;
      5'd11: b = 8'hD3;
      5'd12: b = 8'h00;
      5'd13: b = 8'hD5;
      5'd14: b = 8'h80;
      5'd15: b = 8'hD9;
      5'd16: b = 8'h22;
      5'd17: b = 8'hDB;
      5'd18: b = 8'h20;
      5'd19: b = 8'h8D;
      5'd20: b = 8'h14;
      5'd21: b = 8'hA4;
      5'd22: b = 8'hAF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Column window 0..127, page window 0..7.
  function automatic logic [7:0] addr_byte(input logic [4:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      5'd0: b = 8'h21;
      5'd1: b = 8'h00;
      5'd2: b = 8'h7F;
      5'd3: b = 8'h22;
      5'd4: b = 8'h00;
      5'd5: b = 8'h07;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= POR_HIGH;
      cnt        <= '0;
      idx        <= '0;
      oled_reset <= 1'b1;
      busy       <= 1'b1;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      fb_lock    <= 1'b0;
      fb_addr    <= '0;
      byte_valid <= 1'b0;
      byte_dc    <= 1'b0;
      byte_data  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        POR_HIGH: begin
          if (cnt == WAIT_LAST) begin
            cnt        <= '0;
            oled_reset <= 1'b0;
            state      <= POR_LOW;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        POR_LOW: begin
          if (cnt == WAIT_LAST) begin
            cnt        <= '0;
            oled_reset <= 1'b1;
            state      <= POR_HIGH2;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        POR_HIGH2: begin
          if (cnt == WAIT_LAST) begin
            cnt        <= '0;
            idx        <= '0;
            byte_valid <= 1'b1;
            byte_dc    <= 1'b0;
            byte_data  <= init_byte(5'd0);
            state      <= INIT_CMD;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        INIT_CMD: begin
          if (byte_valid && byte_ready) begin
            if (idx == INIT_LAST) begin
              byte_valid <= 1'b0;
              init_done  <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              idx       <= idx + 5'd1;
              byte_data <= init_byte(idx + 5'd1);
            end
          end
        end
        IDLE: begin
          if (frame_req) begin
            busy       <= 1'b1;
            fb_lock    <= 1'b1;
            idx        <= '0;
            byte_valid <= 1'b1;
            byte_dc    <= 1'b0;
            byte_data  <= addr_byte(5'd0);
            state      <= ADDR_CMD;
          end
        end
        ADDR_CMD: begin
          if (byte_valid && byte_ready) begin
            if (idx == ADDR_LAST) begin
              byte_valid <= 1'b0;
              fb_addr    <= '0;
              state      <= FB_FETCH;
            end else begin
              idx       <= idx + 5'd1;
              byte_data <= addr_byte(idx + 5'd1);
            end
          end
        end
        FB_FETCH: state <= FB_WAIT;
        FB_WAIT: begin
          byte_data  <= fb_rdata;
          byte_dc    <= 1'b1;
          byte_valid <= 1'b1;
          state      <= FB_SEND;
        end
        FB_SEND: begin
          if (byte_valid && byte_ready) begin
            byte_valid <= 1'b0;
            if (fb_addr == LAST_ADDR) begin
              frame_done <= 1'b1;
              fb_lock    <= 1'b0;
              state      <= DONE;
            end else begin
              fb_addr <= fb_addr + ADDR_W'(1);
              state   <= FB_FETCH;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= POR_HIGH;
      endcase
    end
  end

endmodule
